spi_peripheral: RTL and testbench

//  SPI responder (mode 0: CPOL=0, CPHA=0), MSB first; responder end of the bus the SPI controller drives.

---
 rtl/spi_peripheral.sv | 223 ++++++++++++++++++++++
 tb/tb_spi_peripheral.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder: oversamples SCLK/CS_n/MOSI in the i_clk domain, deserialises MOSI into words
// and serialises MISO from a one-deep TX holding buffer.
`timescale 1ns/1ps
module spi_peripheral #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sclk,
  input  logic             i_cs_n,
  input  logic             i_mosi,
  output logic             o_miso,
  output logic             o_miso_en,
  input  logic [WIDTH-1:0] i_tx_data,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_rx_valid,
  output logic             o_busy,
  output logic             o_underrun
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   cs_hist_q, cs_hist_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic [WIDTH-1:0]       buf_q, buf_d;
  logic                   buf_full_q, buf_full_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   underrun_q, underrun_d;
  logic                   miso_q, miso_d;
  logic                   miso_en_q, miso_en_d;
  logic                   busy_q, busy_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;
  logic consume_s, load_s;

  // Synchroniser shift and edge detection against one history flop.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_hist_d = sclk_s;
    cs_hist_d   = cs_s;
    sclk_rise_s = sclk_s & ~sclk_hist_q;
    sclk_fall_s = ~sclk_s & sclk_hist_q;
    cs_fall_s   = ~cs_s & cs_hist_q;
    cs_rise_s   = cs_s & ~cs_hist_q;
  end

  // Frame FSM: next state, shift registers, bit counter and status pulses.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    miso_en_d  = miso_en_q;
    consume_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        miso_en_d  = 1'b0;
        bit_cnt_d  = '0;
        tx_shift_d = '0;
        if (cs_fall_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cs_rise_s) begin
          state_d    = ST_IDLE;
          miso_en_d  = 1'b0;
          tx_shift_d = '0;
        end else begin
          consume_s  = 1'b1;
          tx_shift_d = buf_full_q ? buf_q : '0;
          underrun_d = ~buf_full_q;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          miso_en_d  = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // CS_n deassertion takes priority over any SCLK edge seen in the same cycle.
        if (cs_rise_s) begin
          state_d    = ST_IDLE;
          bit_cnt_d  = '0;
          miso_en_d  = 1'b0;
          tx_shift_d = '0;
          rx_shift_d = '0;
        end else if (sclk_rise_s) begin
          rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
          if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
            rx_data_d  = {rx_shift_q[WIDTH-2:0], mosi_s};
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall_s) begin
          if (bit_cnt_q == CNT_W'(0)) begin
            consume_s  = 1'b1;
            tx_shift_d = buf_full_q ? buf_q : '0;
            underrun_d = ~buf_full_q;
          end else begin
            tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        bit_cnt_d  = '0;
        miso_en_d  = 1'b0;
        tx_shift_d = '0;
      end
    endcase
  end

  // TX holding buffer: a word loaded in the same cycle as an empty-buffer consume waits for the next frame.
  always_comb begin
    load_s = i_tx_valid & tx_ready_q;
    if (consume_s & buf_full_q) begin
      buf_full_d = 1'b0;
    end else begin
      buf_full_d = buf_full_q;
    end
    if (load_s) begin
      buf_d      = i_tx_data;
      buf_full_d = 1'b1;
    end else begin
      buf_d = buf_q;
    end
    tx_ready_d = ~buf_full_d;
    miso_d     = miso_en_d & tx_shift_d[WIDTH-1];
    busy_d     = ~cs_sync_q[SYNC_STAGES-2];
  end

  // Input synchronisers and edge history, reset to the idle bus levels.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_hist_q <= sclk_hist_d;
      cs_hist_q   <= cs_hist_d;
    end
  end

  // Frame state, shift registers, buffer and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      miso_q     <= 1'b0;
      miso_en_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      miso_q     <= miso_d;
      miso_en_q  <= miso_en_d;
      busy_q     <= busy_d;
    end
  end

  assign o_miso     = miso_q;
  assign o_miso_en  = miso_en_q;
  assign o_tx_ready = tx_ready_q;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_busy     = busy_q;
  assign o_underrun = underrun_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a mode-0 controller model drives SCLK at i_clk/8 while a scoreboard
// monitor pops expected received words on every o_rx_valid pulse.
`timescale 1ns/1ps
module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       miso, miso_en, tx_ready, rx_valid, busy, underrun;
  logic [7:0] rx_data;

  int         vectors = 0;
  int         miscompares = 0;
  int         urun_cnt = 0;
  int         rxv_cnt = 0;
  logic [7:0] exp_rx_q[$];

  spi_peripheral #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
    .o_miso(miso), .o_miso_en(miso_en), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready), .o_rx_data(rx_data), .o_rx_valid(rx_valid), .o_busy(busy),
    .o_underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rx_valid pulse pops one expected word.
  initial begin
    logic [7:0] exp_w;
    forever begin
      @(negedge clk);
      if (underrun === 1'b1) urun_cnt++;
      if (rx_valid === 1'b1) begin
        rxv_cnt++;
        vectors++;
        if (exp_rx_q.size() == 0) begin
          miscompares++;
          $display("FAIL rx_unexpected: got %02h, required no word", rx_data);
        end else begin
          exp_w = exp_rx_q.pop_front();
          if (rx_data !== exp_w) begin
            miscompares++;
            $display("FAIL rx_word: got %02h, required %02h", rx_data, exp_w);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] d);
    int t = 0;
    while (tx_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (tx_ready !== 1'b1) begin
      check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    end else begin
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    wait_clks(5);
  endtask

  // Mode-0 controller: MOSI set while SCLK low, MISO sampled just before the rising edge.
  task automatic xfer(input logic [7:0] w, input int nbits, input bit end_frame, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = w[7-i];
      wait_clks(4);
      got[7-i] = miso;
      sclk = 1'b1;
      wait_clks(4);
      sclk = 1'b0;
      if (end_frame && i == nbits - 1) cs_n = 1'b1;
    end
    if (end_frame) wait_clks(8);
  endtask

  initial begin
    logic [7:0] g1, g2;
    int u0, r0;

    // Reset
    wait_clks(16);
    rst_n = 1'b1;
    wait_clks(2);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_miso_en", {31'd0, miso_en}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);

    // Single frame
    u0 = urun_cnt;
    load_tx(8'hA5);
    check("t2_ready_low", {31'd0, tx_ready}, 32'd0);
    exp_rx_q.push_back(8'h3C);
    cs_low();
    check("t2_ready_after_load", {31'd0, tx_ready}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd1);
    check("t2_miso_en", {31'd0, miso_en}, 32'd1);
    xfer(8'h3C, 8, 1'b1, g1);
    check("t2_miso_word", {24'd0, g1}, 32'hA5);
    check("t2_underruns", urun_cnt - u0, 32'd0);
    check("t2_miso_en_off", {31'd0, miso_en}, 32'd0);

    // Back-to-back under one CS_n
    u0 = urun_cnt;
    load_tx(8'h81);
    exp_rx_q.push_back(8'h11);
    exp_rx_q.push_back(8'h22);
    cs_low();
    fork
      begin
        xfer(8'h11, 8, 1'b0, g1);
        xfer(8'h22, 8, 1'b1, g2);
      end
      load_tx(8'h7E);
    join
    check("t3_miso_word1", {24'd0, g1}, 32'h81);
    check("t3_miso_word2", {24'd0, g2}, 32'h7E);
    check("t3_underruns", urun_cnt - u0, 32'd0);

    // Underrun
    u0 = urun_cnt;
    exp_rx_q.push_back(8'hFF);
    cs_low();
    check("t4_underrun_at_load", urun_cnt - u0, 32'd1);
    xfer(8'hFF, 8, 1'b1, g1);
    check("t4_miso_word", {24'd0, g1}, 32'h00);
    check("t4_underruns", urun_cnt - u0, 32'd1);
    check("t4_rx_held", {24'd0, rx_data}, 32'hFF);

    // Abort after 5 bits, then a full frame
    r0 = rxv_cnt;
    cs_low();
    xfer(8'h9D, 5, 1'b1, g1);
    check("t5_no_rx_valid", rxv_cnt - r0, 32'd0);
    check("t5_miso_en_off", {31'd0, miso_en}, 32'd0);
    check("t5_busy_off", {31'd0, busy}, 32'd0);
    check("t5_miso_low", {31'd0, miso}, 32'd0);
    exp_rx_q.push_back(8'hC3);
    cs_low();
    xfer(8'hC3, 8, 1'b1, g1);
    check("t5_rx_count", rxv_cnt - r0, 32'd1);
    check("t5_rx_data", {24'd0, rx_data}, 32'hC3);

    // Reset mid-frame after 3 bits
    cs_low();
    xfer(8'hE7, 3, 1'b0, g1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_miso_en", {31'd0, miso_en}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("t6_rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("t6_rst_miso", {31'd0, miso}, 32'd0);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(4);
    exp_rx_q.push_back(8'h5A);
    cs_low();
    xfer(8'h5A, 8, 1'b1, g1);
    check("t6_rx_data", {24'd0, rx_data}, 32'h5A);

    wait_clks(10);
    check("rx_queue_drained", exp_rx_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
